// File: rtl/quick_spi_pkg.sv
// Shared encodings for the quick_spi_multi master: FSM states, byte/bit ordering
// selectors and operation codes.
package quick_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_TRANSFER = 3'd2,
    ST_HOLD     = 3'd3,
    ST_DONE     = 3'd4
  } spi_state_e;

  localparam bit BYTES_LITTLE   = 1'b0;
  localparam bit BYTES_BIG      = 1'b1;
  localparam bit BITS_LSB_FIRST = 1'b0;
  localparam bit BITS_MSB_FIRST = 1'b1;
  localparam logic OP_WRITE     = 1'b0;
  localparam logic OP_READ      = 1'b1;

endpackage

// File: rtl/quick_spi_sclk_gen.sv
// Divides clk into CLK_DIV-spaced ticks; while edges are enabled each tick toggles
// sclk and is flagged as a leading (away from CPOL) or trailing (back to CPOL) edge.
module quick_spi_sclk_gen #(
  parameter int CLK_DIV = 1,
  parameter bit CPOL    = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic edge_en,
  output logic tick,
  output logic lead,
  output logic trail,
  output logic sclk
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_r;
  logic          sclk_r;

  // Edge strobes decoded from the divider; sclk_r still holds the pre-edge level.
  always_comb begin
    tick  = run && (cnt_r == LAST);
    lead  = tick && edge_en && (sclk_r == CPOL);
    trail = tick && edge_en && (sclk_r != CPOL);
  end

  // Divider counter and sclk level; stopping parks sclk at its idle level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r  <= '0;
      sclk_r <= CPOL;
    end else if (!run) begin
      cnt_r  <= '0;
      sclk_r <= CPOL;
    end else begin
      cnt_r <= tick ? '0 : cnt_r + CW'(1);
      if (tick && edge_en) begin
        sclk_r <= ~sclk_r;
      end
    end
  end

  assign sclk = sclk_r;

endmodule

// File: rtl/quick_spi_multi.sv
// Multi-slave SPI master: one transaction of 1..MAX_BYTES bytes per request, either
// write (mosi) or read (miso), with configurable byte/bit order, CPOL, CPHA and rate.
module quick_spi_multi
  import quick_spi_pkg::*;
#(
  parameter int SLAVES_COUNT = 2,
  parameter int MAX_BYTES    = 4,
  parameter bit BYTES_ORDER  = 1'b0,
  parameter bit BITS_ORDER   = 1'b1,
  parameter bit CPOL         = 1'b0,
  parameter bit CPHA         = 1'b0,
  parameter int CLK_DIV      = 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               enable,
  input  logic                               start_transaction,
  input  logic [$clog2(SLAVES_COUNT)-1:0]    slave,
  input  logic                               operation,
  input  logic [$clog2(MAX_BYTES+1)-1:0]     byte_count,
  input  logic [8*MAX_BYTES-1:0]             outgoing_data,
  output logic [8*MAX_BYTES-1:0]             incoming_data,
  output logic                               busy,
  output logic                               end_of_transaction,
  output logic                               mosi,
  input  logic                               miso,
  output logic                               sclk,
  output logic [SLAVES_COUNT-1:0]            ss_n
);

  localparam int TW  = 8 * MAX_BYTES;
  localparam int IW  = $clog2(TW);
  localparam int SW  = $clog2(SLAVES_COUNT);
  localparam int NBW = $clog2(MAX_BYTES + 1);
  localparam int EW  = $clog2(16 * MAX_BYTES + 1);

  spi_state_e          state_r;
  logic                op_r;
  logic [NBW-1:0]      nbytes_r;
  logic [TW-1:0]       tx_sr_r;
  logic [TW-1:0]       rx_sr_r;
  logic [EW-1:0]       edge_cnt_r;
  logic [SLAVES_COUNT-1:0] ss_n_r;
  logic                mosi_r;
  logic                busy_r;
  logic                eot_r;
  logic [TW-1:0]       incoming_r;

  logic                run_s, edge_en_s, tick_s, lead_s, trail_s;
  logic                shift_s, sample_s;
  logic [EW-1:0]       last_edge_s;
  logic [TW-1:0]       tx_stream_s;

  function automatic logic [NBW-1:0] eff_bytes(input logic [NBW-1:0] bc);
    if ((bc == '0) || (int'(bc) > MAX_BYTES)) return NBW'(MAX_BYTES);
    else return bc;
  endfunction

  // Position p of the serial stream (p = 0 goes first) lives at stream bit TW-1-p.
  function automatic int stream_index(input int p, input int nb);
    int byte_i, bit_i;
    byte_i = (BYTES_ORDER == BYTES_BIG) ? (nb - 1 - p / 8) : (p / 8);
    bit_i  = (BITS_ORDER == BITS_MSB_FIRST) ? (7 - p % 8) : (p % 8);
    return 8 * byte_i + bit_i;
  endfunction

  function automatic logic [TW-1:0] serialize(input logic [TW-1:0] data, input logic [NBW-1:0] n);
    logic [TW-1:0] s;
    s = '0;
    for (int p = 0; p < TW; p++) begin
      if (p < 8 * int'(n)) s[IW'(TW - 1 - p)] = data[IW'(stream_index(p, int'(n)))];
    end
    return s;
  endfunction

  function automatic logic [TW-1:0] deserialize(input logic [TW-1:0] sr, input logic [NBW-1:0] n);
    logic [TW-1:0] d;
    d = '0;
    for (int p = 0; p < TW; p++) begin
      if (p < 8 * int'(n)) d[IW'(stream_index(p, int'(n)))] = sr[IW'(8 * int'(n) - 1 - p)];
    end
    return d;
  endfunction

  function automatic logic [SLAVES_COUNT-1:0] select_n(input logic [SW-1:0] s);
    logic [SLAVES_COUNT-1:0] r;
    r = '1;
    for (int i = 0; i < SLAVES_COUNT; i++) begin
      if (int'(s) == i) r[i] = 1'b0;
    end
    return r;
  endfunction

  // Divider runs through SETUP..HOLD; sclk edges are only issued in SETUP/TRANSFER.
  always_comb begin
    run_s       = enable && ((state_r == ST_SETUP) || (state_r == ST_TRANSFER) || (state_r == ST_HOLD));
    edge_en_s   = (state_r == ST_SETUP) || (state_r == ST_TRANSFER);
    shift_s     = CPHA ? lead_s : trail_s;
    sample_s    = CPHA ? trail_s : lead_s;
    last_edge_s = EW'({nbytes_r, 4'b0000});
    if (operation == OP_READ) begin
      tx_stream_s = '0;
    end else begin
      tx_stream_s = serialize(outgoing_data, eff_bytes(byte_count));
    end
  end

  quick_spi_sclk_gen #(
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_sclk_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (run_s),
    .edge_en (edge_en_s),
    .tick    (tick_s),
    .lead    (lead_s),
    .trail   (trail_s),
    .sclk    (sclk)
  );

  // Transaction FSM with registered ss_n/mosi/busy/eot/incoming_data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      op_r       <= OP_WRITE;
      nbytes_r   <= '0;
      tx_sr_r    <= '0;
      rx_sr_r    <= '0;
      edge_cnt_r <= '0;
      ss_n_r     <= '1;
      mosi_r     <= 1'b0;
      busy_r     <= 1'b0;
      eot_r      <= 1'b0;
      incoming_r <= '0;
    end else if ((state_r != ST_IDLE) && !enable) begin
      state_r    <= ST_IDLE;
      edge_cnt_r <= '0;
      ss_n_r     <= '1;
      mosi_r     <= 1'b0;
      busy_r     <= 1'b0;
      eot_r      <= 1'b0;
    end else begin
      if (shift_s) begin
        mosi_r  <= tx_sr_r[TW-1];
        tx_sr_r <= tx_sr_r << 1;
      end
      if (sample_s) begin
        rx_sr_r <= {rx_sr_r[TW-2:0], miso};
      end
      case (state_r)
        ST_IDLE: begin
          eot_r <= 1'b0;
          if (start_transaction && enable) begin
            state_r    <= ST_SETUP;
            op_r       <= operation;
            nbytes_r   <= eff_bytes(byte_count);
            ss_n_r     <= select_n(slave);
            busy_r     <= 1'b1;
            edge_cnt_r <= '0;
            rx_sr_r    <= '0;
            // CPHA=0 presents the first bit before the first edge.
            tx_sr_r    <= CPHA ? tx_stream_s : (tx_stream_s << 1);
            mosi_r     <= CPHA ? 1'b0 : tx_stream_s[TW-1];
          end
        end
        ST_SETUP: begin
          if (tick_s) begin
            state_r    <= ST_TRANSFER;
            edge_cnt_r <= EW'(1);
          end
        end
        ST_TRANSFER: begin
          if (tick_s) begin
            edge_cnt_r <= edge_cnt_r + EW'(1);
            if ((edge_cnt_r + EW'(1)) == last_edge_s) state_r <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (tick_s) begin
            state_r <= ST_DONE;
            ss_n_r  <= '1;
            busy_r  <= 1'b0;
            eot_r   <= 1'b1;
            mosi_r  <= 1'b0;
            if (op_r == OP_READ) incoming_r <= deserialize(rx_sr_r, nbytes_r);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          eot_r   <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          ss_n_r  <= '1;
          busy_r  <= 1'b0;
          eot_r   <= 1'b0;
        end
      endcase
    end
  end

  assign ss_n               = ss_n_r;
  assign mosi               = mosi_r;
  assign busy               = busy_r;
  assign end_of_transaction = eot_r;
  assign incoming_data      = incoming_r;

endmodule
